// File: rtl/spi_pkg.sv
// SPI controller shared definitions: byte width, mode encodings, FSM states, CPOL/CPHA helpers.
// Latency: none (declarations only).
// Backpressure: not applicable.
package spi_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] SPI_MODE0 = 2'd0;
    localparam logic [1:0] SPI_MODE1 = 2'd1;
    localparam logic [1:0] SPI_MODE2 = 2'd2;
    localparam logic [1:0] SPI_MODE3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } spi_state_t;

    // Clock polarity: idle level of sclk.
    function automatic logic cpol(input logic [1:0] mode);
        return mode[1];
    endfunction

    // Clock phase: 0 = data valid before the leading edge, 1 = data driven on the leading edge.
    function automatic logic cpha(input logic [1:0] mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// Half-period timer: counts 0..CLK_DIV-1 while enabled and pulses tick on the terminal count.
// Latency: first tick CLK_DIV cycles after en rises, then one every CLK_DIV cycles.
// Backpressure: none; clearing en returns the counter to 0.
module spi_clk_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == TERM);

    // Free-running half-period counter, held at zero whenever the controller is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || (cnt == TERM)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_ctrl.sv
// SPI master: serialises one byte MSB-first with CPOL/CPHA modes 0..3; optional MISO capture (SPI_CTRL_MISO_RX_EN).
// Latency: cs falls one cycle after handshake; done pulses 1+17*CLK_DIV cycles after handshake.
// Backpressure: tx_ready is low from the cycle after handshake until done; tx_valid is ignored meanwhile.
module spi_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [1:0]        mode,
    output logic              sclk,
    output logic              mosi,
    output logic              cs,
    output logic              busy,
    output logic              done
`ifdef SPI_CTRL_MISO_RX_EN
    ,
    input  logic              miso,
    output logic [BYTE_W-1:0] rx_data
`endif
);

    spi_state_t        state;
    logic [BYTE_W-1:0] shift_reg;
    logic [1:0]        mode_q;
    logic [3:0]        bit_cnt;
    logic              tick;
    logic              lead_edge;
`ifdef SPI_CTRL_MISO_RX_EN
    logic [BYTE_W-1:0] rx_shift;
`endif

    spi_clk_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (state != IDLE),
        .tick(tick)
    );

    // bit_cnt holds the index of the toggle about to happen; even index = leading edge.
    assign lead_edge = ~bit_cnt[0];

    // Transfer sequencer: IDLE -> LEAD -> SHIFT (16 sclk toggles) -> TRAIL -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cs        <= 1'b1;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tx_ready  <= 1'b1;
            shift_reg <= '0;
            mode_q    <= '0;
            bit_cnt   <= '0;
`ifdef SPI_CTRL_MISO_RX_EN
            rx_shift  <= '0;
            rx_data   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Track the live CPOL so sclk already idles correctly before cs falls.
                    sclk <= cpol(mode);
                    if (tx_valid && tx_ready) begin
                        shift_reg <= tx_data;
                        mode_q    <= mode;
                        bit_cnt   <= '0;
                        cs        <= 1'b0;
                        busy      <= 1'b1;
                        tx_ready  <= 1'b0;
                        state     <= LEAD;
                        // CPHA=0 receivers sample on the first edge, so bit7 must be set up now.
                        if (!cpha(mode)) begin
                            mosi <= tx_data[BYTE_W-1];
                        end
                    end
                end
                LEAD, SHIFT: begin
                    if (tick) begin
                        sclk <= ~sclk;
                        if (cpha(mode_q)) begin
                            // Drive the next bit on each leading edge.
                            if (lead_edge) begin
                                mosi      <= shift_reg[BYTE_W-1];
                                shift_reg <= {shift_reg[BYTE_W-2:0], 1'b0};
                            end
                        end else if (!lead_edge && (bit_cnt != 4'd15)) begin
                            // Advance on trailing edges; bit0 stays on the line after the last one.
                            mosi      <= shift_reg[BYTE_W-2];
                            shift_reg <= {shift_reg[BYTE_W-2:0], 1'b0};
                        end
`ifdef SPI_CTRL_MISO_RX_EN
                        // Sample edge is the leading edge for CPHA=0, trailing for CPHA=1.
                        if (lead_edge != cpha(mode_q)) begin
                            rx_shift <= {rx_shift[BYTE_W-2:0], miso};
                        end
`endif
                        if (bit_cnt == 4'd15) begin
                            state <= TRAIL;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            state   <= SHIFT;
                        end
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        cs       <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
`ifdef SPI_CTRL_MISO_RX_EN
                        rx_data  <= rx_shift;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ctrl.sv
// Bench for spi_ctrl: cycle-level behavioural model plus an SPI peripheral that captures bytes from the wires.
// Stimulus: directed scenarios followed by random bytes/modes/gaps.
// Outputs compared on every negedge.
module tb_spi_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [1:0] mode;
    logic       tx_ready, sclk, mosi, cs, busy, done;
`ifdef SPI_CTRL_MISO_RX_EN
    logic [7:0] rx_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_ctrl #(
        .CLK_DIV(D)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .mode    (mode),
        .sclk    (sclk),
        .mosi    (mosi),
        .cs      (cs),
        .busy    (busy),
        .done    (done)
`ifdef SPI_CTRL_MISO_RX_EN
        ,
        .miso    (mosi),
        .rx_data (rx_data)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic       chk_on   = 1'b0;
    logic       m_active = 1'b0;
    int         m_k      = 0;
    logic [7:0] m_byte   = 8'h00;
    logic [1:0] m_mode   = 2'd0;
    logic       e_cs = 1'b1, e_sclk = 1'b0, e_mosi = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_rdy = 1'b1;
    logic [7:0] e_rx = 8'h00;
    logic [7:0] expq[$];

    // Bit on mosi after n sclk toggles of a transfer.
    function automatic logic exp_mosi(input logic [7:0] b, input logic ph, input int n, input logic prev);
        int idx;
        if (!ph) begin
            idx = 7 - n / 2;
        end else begin
            if (n == 0) return prev;
            idx = 7 - (n - 1) / 2;
        end
        if (idx < 0) idx = 0;
        return b[idx];
    endfunction

    always @(posedge clk) begin
        int n;
        if (rst) begin
            chk_on   = 1'b1;
            m_active = 1'b0;
            e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_rdy = 1'b1;
            e_rx = 8'h00;
            expq.delete();
        end else begin
            e_done = 1'b0;
            if (!m_active) begin
                e_sclk = mode[1];
                if (tx_valid && e_rdy) begin
                    m_active = 1'b1;
                    m_k      = 1;
                    m_byte   = tx_data;
                    m_mode   = mode;
                    expq.push_back(tx_data);
                    e_cs = 1'b0; e_busy = 1'b1; e_rdy = 1'b0;
                    if (!mode[0]) e_mosi = tx_data[7];
                end
            end else begin
                m_k++;
                if (m_k == 17 * D + 1) begin
                    m_active = 1'b0;
                    e_cs = 1'b1; e_busy = 1'b0; e_done = 1'b1; e_rdy = 1'b1;
                    e_rx = m_byte;
                end else begin
                    n = (m_k - 1) / D;
                    if (n > 16) n = 16;
                    e_sclk = m_mode[1] ^ (n % 2 == 1);
                    e_mosi = exp_mosi(m_byte, m_mode[0], n, e_mosi);
                end
            end
        end
    end

    // ---------------- compare process + peripheral ----------------
    logic       prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
    logic [7:0] p_cap = 8'h00, p_last = 8'h00;
    int         p_bits = 0, p_tog = 0, p_rise = 0, p_low = 0;
    int         l_tog = 0, l_rise = 0, l_low = 0, done_total = 0;

    always @(negedge clk) begin
        logic [7:0] e;
        if (chk_on) begin
            chk("cs", cs, e_cs);
            chk("sclk", sclk, e_sclk);
            chk("mosi", mosi, e_mosi);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("tx_ready", tx_ready, e_rdy);
`ifdef SPI_CTRL_MISO_RX_EN
            chk("rx_data", rx_data, e_rx);
`endif
            if (done) done_total++;
            if (prev_cs && !cs) begin
                p_cap = 8'h00; p_bits = 0; p_tog = 0; p_rise = 0; p_low = 0;
            end
            if (!prev_cs && !cs && (sclk != prev_sclk)) begin
                p_tog++;
                if (sclk) p_rise++;
                // Peripheral samples on posedge in modes 0/3 and negedge in modes 1/2.
                if (sclk == (m_mode == 2'd0 || m_mode == 2'd3)) begin
                    p_cap = {p_cap[6:0], prev_mosi};
                    p_bits++;
                end
            end
            if (!cs) p_low++;
            if (!prev_cs && cs && (expq.size() > 0)) begin
                e = expq.pop_front();
                chk("periph_byte", p_cap, e);
                chk("periph_bits", p_bits, 8);
                chk("sclk_toggles", p_tog, 16);
                chk("cs_low_cycles", p_low, 17 * D);
                p_last = p_cap; l_tog = p_tog; l_rise = p_rise; l_low = p_low;
            end
            prev_cs = cs; prev_sclk = sclk; prev_mosi = mosi;
        end
    end

    // ---------------- stimulus ----------------
    task automatic start(input logic [7:0] d, input logic [1:0] m);
        tx_data  = d;
        mode     = m;
        tx_valid = 1'b1;
        for (int i = 0; i < 17 * D + 20; i++) begin
            if (tx_ready) break;
            @(negedge clk);
        end
        chk("handshake_ready", tx_ready, 1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 17 * D + 20; i++) begin
            if (done) break;
            @(negedge clk);
        end
        chk("done_timeout", done, 1'b1);
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] m);
        start(d, m);
        wait_done();
    endtask

    initial begin
        int d0;
        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; mode = 2'd2;

        // Reset with mode 2: sclk low during reset, follows CPOL one cycle after release.
        repeat (3) @(negedge clk);
        chk("rst_cs", cs, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_sclk", sclk, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_sclk", sclk, 1'b1);

        // Mode 0, 0xA5.
        d0 = done_total;
        send(8'hA5, 2'd0);
        repeat (3) @(negedge clk);
        chk("a5_byte", p_last, 8'hA5);
        chk("a5_rising_edges", l_rise, 8);
        chk("a5_cs_low", l_low, 68);
        chk("a5_done_pulses", done_total - d0, 1);

        // Modes 1..3 with 0x3C.
        for (int m = 1; m < 4; m++) begin
            send(8'h3C, 2'(m));
            chk("idle_cpol", sclk, m >= 2);
            @(negedge clk);
            chk("mode_byte", p_last, 8'h3C);
            chk("mode_toggles", l_tog, 16);
        end

        // Back-to-back with tx_valid held high.
        tx_data = 8'h01; mode = 2'd0; tx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (tx_ready) break;
            @(negedge clk);
        end
        @(negedge clk);
        tx_data = 8'hFF;
        for (int i = 0; i < 17 * D + 20; i++) begin
            if (tx_ready) break;
            @(negedge clk);
        end
        chk("b2b_hs_in_done_cycle", done, 1'b1);
        chk("b2b_cs_gap_high", cs, 1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("b2b_cs_gap_one_cycle", cs, 1'b0);
        chk("b2b_first_byte", p_last, 8'h01);
        wait_done();
        @(negedge clk);
        chk("b2b_second_byte", p_last, 8'hFF);

        // Inputs changed mid-transfer are ignored.
        start(8'h96, 2'd1);
        repeat (3 * D) @(negedge clk);
        tx_data = 8'($urandom);
        mode    = 2'($urandom);
        wait_done();
        @(negedge clk);
        chk("midchange_byte", p_last, 8'h96);

        // Reset after toggle 7 aborts with no done pulse.
        start(8'h33, 2'd0);
        repeat (7 * D) @(negedge clk);
        d0  = done_total;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_cs", cs, 1'b1);
        chk("abort_done", done, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_no_done", done_total - d0, 0);
        send(8'h5A, 2'd0);
        @(negedge clk);
        chk("after_abort_byte", p_last, 8'h5A);

`ifdef SPI_CTRL_MISO_RX_EN
        send(8'hC3, 2'd3);
        chk("rx_loopback", rx_data, 8'hC3);
`endif

        // Random traffic.
        for (int t = 0; t < 12; t++) begin
            int gap;
            gap = $urandom_range(3);
            for (int g = 0; g < gap; g++) begin
                mode = 2'($urandom);
                @(negedge clk);
            end
            send(8'($urandom), 2'($urandom));
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=400000", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_ctrl.md
Name: spi_ctrl

Overview:
- SPI controller (master) that sits directly upstream of the SPI peripheral receiver.
- Takes a parallel byte over a valid/ready handshake and serialises it MSB-first on mosi.
- Generates sclk and active-low cs for all four CPOL/CPHA modes (mode[1]=CPOL, mode[0]=CPHA).
- Edge placement is chosen so that a receiver sampling on posedge in modes 0/3 and negedge in modes 1/2 captures the byte exactly.

Parameters:
CLK_DIV, 4, clk cycles per sclk half-period; legal range ≥1; also sets cs lead and trail time
CNT_W, $clog2(CLK_DIV+1), width of the half-period counter (derived, not overridden)

Ports:
clk  input  1  system clock; all logic is on posedge
rst  input  1  synchronous reset, active-high
tx_data  input  8  byte to send; sampled only on handshake
tx_valid  input  1  request to send tx_data
tx_ready  output  1  high in IDLE; handshake completes when tx_valid && tx_ready
mode  input  2  SPI mode 0..3; latched on handshake
sclk  output  1  serial clock
mosi  output  1  serial data out, MSB first
cs  output  1  chip select, active-low
busy  output  1  high from the cycle after handshake until cs deasserts
done  output  1  one-cycle pulse when cs deasserts

Behaviour:
Reset values (registered, applied on rst at posedge):
- cs=1, sclk=0, mosi=0, busy=0, done=0, tx_ready=1.
- State=IDLE; all counters=0.
- rst asserted mid-transfer aborts on that same edge: cs returns to 1 with no done pulse, and the partial byte is discarded.

States: IDLE -> LEAD -> SHIFT -> TRAIL -> IDLE.
- All outputs are registered.

IDLE:
- tx_ready=1.
- sclk follows live mode[1] (CPOL), with one cycle of register delay.
- On the handshake (cycle T):
  - latch tx_data into shift_reg and mode into mode_q.
  - next state LEAD.
  - at T+1: cs=0, busy=1, tx_ready=0.
  - mosi=tx_data[7] at T+1 if CPHA=0; for CPHA=1 mosi holds its previous value.

LEAD:
- Lasts CLK_DIV cycles.
- sclk=CPOL.

SHIFT:
- 16 sclk toggles, one every CLK_DIV cycles.
- First toggle at T+1+CLK_DIV; last toggle at T+1+16*CLK_DIV.
- Odd toggles are leading edges; even toggles are trailing edges.
- CPHA=0: mosi advances to the next bit on trailing edges 2,4,…,14. After toggle 16, mosi holds bit0.
- CPHA=1: mosi presents bit7,6,…,0 on leading edges 1,3,…,15.
- After toggle 16, sclk is back at CPOL.

TRAIL:
- Lasts CLK_DIV cycles, cs still 0.
- Exit at T+1+17*CLK_DIV: cs=1, busy=0, done=1 for one cycle, tx_ready=1, state IDLE.
- A new handshake is allowed in that same cycle.
- Back-to-back transfers therefore give cs high for at least one cycle between bytes.

Other rules:
- mode or tx_data changes during a transfer are ignored; the latched copies are used.
- tx_valid while busy is ignored; tx_ready=0 applies backpressure.
- Bit counter runs 0..15 (4 bits) and has no wrap-around within a transfer.
- Half-period counter counts 0..CLK_DIV-1, reloads to 0, and issues a tick on terminal count.
- CLK_DIV=1: sclk toggles every clk cycle; the state sequence is unchanged.

Optional Feature:
Macro: SPI_CTRL_MISO_RX_EN
- Defined:
  - adds ports miso (input, 1) and rx_data (output, 8, reset 0).
  - miso is sampled on the sample edge: leading edge when CPHA=0, trailing edge when CPHA=1.
  - sampled bits are shifted MSB-first.
  - rx_data updates in the cycle done pulses and holds until the next done.
- Undefined: the ports are absent and there is no receive logic; tx behaviour is identical.

Decomposition:
- Package spi_pkg:
  - mode localparams SPI_MODE0..3.
  - state enum (IDLE, LEAD, SHIFT, TRAIL).
  - cpol(mode)/cpha(mode) helper functions.
  - BYTE_W=8.
- Sub-module spi_clk_tick: parameterised CLK_DIV half-period counter with enable, producing a one-cycle tick; reset is synchronous.

Test Plan:
- Reset: hold rst 3 cycles, mode=2 -> cs=1, busy=0, tx_ready=1, done=0; sclk=0 during reset and 1 one cycle after release.
- Mode 0, CLK_DIV=4, tx_data=0xA5:
  - 8 rising edges, with mosi sampled at rising edges reading 1,0,1,0,0,1,0,1.
  - cs low exactly 68 cycles; done pulses once; a spi_peripheral model in mode 0 captures 0xA5.
- Modes 1, 2, 3 with 0x3C -> sclk idles at CPOL; sampling on the mode-appropriate edge recovers 0x3C; 16 sclk toggles per transfer.
- Back-to-back: tx_valid held high with 0x01 then 0xFF -> second handshake in the done cycle; cs high for exactly 1 cycle between bytes; both bytes correct.
- Mid-transfer change plus reset:
  - changing mode/tx_data during SHIFT has no effect.
  - asserting rst after toggle 7 -> cs=1 on the next edge, no done pulse; the next transfer with 0x5A completes correctly.
- With SPI_CTRL_MISO_RX_EN and miso looped to mosi, mode 3, 0xC3 -> rx_data=0xC3 in the done cycle.
